// File: rtl/seq_serializer_if.sv
// rtl/seq_serializer_if.sv - word handshake and serial-output bundle for seq_serializer
// master drives words in; slave (the serializer) returns ready, serial stream and status.
interface seq_serializer_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  logic [WIDTH-1:0]             data_i;
  logic                         valid_i;
  logic                         ready_o;
  logic                         seq_o;
  logic                         seq_valid_o;
  logic                         busy_o;
  logic [$clog2(DEPTH+1)-1:0]   level_o;

  modport master (
    output data_i, valid_i,
    input  ready_o, seq_o, seq_valid_o, busy_o, level_o
  );

  modport slave (
    input  data_i, valid_i,
    output ready_o, seq_o, seq_valid_o, busy_o, level_o
  );
endinterface

// File: rtl/seq_serializer.sv
// rtl/seq_serializer.sv - FIFO-buffered parallel-to-serial shifter feeding seq_detector_struct
// Optional even-parity bit per word when SEQ_SERIALIZER_PARITY_EN is defined.
module seq_serializer #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 4,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  seq_serializer_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int LW = $clog2(DEPTH + 1);
  localparam int CW = $clog2(WIDTH);

`ifdef SEQ_SERIALIZER_PARITY_EN
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SHIFT = 2'd1, ST_PARITY = 2'd2} state_t;
`else
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SHIFT = 2'd1} state_t;
`endif

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [PW-1:0]    w_level;
  logic             w_push;
  logic             w_pop;
  logic             w_has_word;
  logic [WIDTH-1:0] w_head;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cnt_nxt;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] w_shift_nxt;
  logic [WIDTH-1:0] w_shifted;
  logic             w_seq_nxt;
  logic             r_seq;
  logic             r_seq_valid;
  logic             r_busy;
`ifdef SEQ_SERIALIZER_PARITY_EN
  logic             r_par;
  logic             w_par_nxt;
`endif

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign w_level     = r_wptr - r_rptr;
  assign w_has_word  = (w_level != '0);
  assign bus.ready_o = (w_level != PW'(DEPTH));
  assign bus.level_o = LW'(w_level);
  assign w_push      = bus.valid_i && bus.ready_o;
  assign w_head      = r_mem[r_rptr[AW-1:0]];
  assign w_shifted   = (MSB_FIRST != 0) ? (r_shift << 1) : (r_shift >> 1);

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wptr[AW-1:0]] <= bus.data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_shift_nxt = r_shift;
    w_pop       = 1'b0;
    w_seq_nxt   = 1'b0;
`ifdef SEQ_SERIALIZER_PARITY_EN
    w_par_nxt   = r_par;
`endif

    case (r_state)
      ST_IDLE: begin
        w_pop = w_has_word;
      end
      ST_SHIFT: begin
        if (r_cnt == CW'(WIDTH - 1)) begin
`ifdef SEQ_SERIALIZER_PARITY_EN
          w_state_nxt = ST_PARITY;
`else
          w_pop       = w_has_word;
          w_state_nxt = ST_IDLE;
`endif
        end else begin
          w_shift_nxt = w_shifted;
          w_cnt_nxt   = r_cnt + 1'b1;
        end
      end
`ifdef SEQ_SERIALIZER_PARITY_EN
      ST_PARITY: begin
        w_pop       = w_has_word;
        w_state_nxt = ST_IDLE;
      end
`endif
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    // A pop always reloads the shifter, overriding any IDLE fallback above.
    if (w_pop) begin
      w_shift_nxt = w_head;
      w_cnt_nxt   = '0;
      w_state_nxt = ST_SHIFT;
`ifdef SEQ_SERIALIZER_PARITY_EN
      w_par_nxt   = ^w_head;
`endif
    end

    case (w_state_nxt)
      ST_SHIFT:  w_seq_nxt = (MSB_FIRST != 0) ? w_shift_nxt[WIDTH-1] : w_shift_nxt[0];
`ifdef SEQ_SERIALIZER_PARITY_EN
      ST_PARITY: w_seq_nxt = w_par_nxt;
`endif
      default:   w_seq_nxt = 1'b0;
    endcase
  end

  // Outputs are registered from next-state values so they align with r_state.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_shift     <= '0;
      r_seq       <= 1'b0;
      r_seq_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_shift     <= w_shift_nxt;
      r_seq       <= w_seq_nxt;
      r_seq_valid <= (w_state_nxt != ST_IDLE);
      r_busy      <= (w_state_nxt != ST_IDLE);
    end
  end

`ifdef SEQ_SERIALIZER_PARITY_EN
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_par <= 1'b0;
    end else begin
      r_par <= w_par_nxt;
    end
  end
`endif

  assign bus.seq_o       = r_seq;
  assign bus.seq_valid_o = r_seq_valid;
  assign bus.busy_o      = r_busy;

endmodule

// File: tb/tb_seq_serializer.sv
// tb/tb_seq_serializer.sv - self-checking bench for seq_serializer against a queue-based model
module tb_seq_serializer;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH + 1);
`ifdef SEQ_SERIALIZER_PARITY_EN
  localparam int NBITS = WIDTH + 1;
`else
  localparam int NBITS = WIDTH;
`endif

  logic clk_i;
  logic rstn_i;
  int   errors;
  int   checks;

  seq_serializer_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_if ();

  seq_serializer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .MSB_FIRST(1)) u_dut (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .bus    (u_if)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  // Model: FIFO of words and a queue of serial bits still to be shown; head bit is on seq_o.
  logic [WIDTH-1:0] m_fifo [$];
  logic             m_sh   [$];

  task automatic word_bits(input logic [WIDTH-1:0] w, inout logic q [$]);
    for (int i = WIDTH - 1; i >= 0; i--) q.push_back(w[i]);
`ifdef SEQ_SERIALIZER_PARITY_EN
    q.push_back(^w);
`endif
  endtask

  task automatic model_edge();
    int               pre;
    logic [WIDTH-1:0] w;
    if (!rstn_i) begin
      m_fifo.delete();
      m_sh.delete();
    end else begin
      pre = m_fifo.size();
      if (m_sh.size() != 0) void'(m_sh.pop_front());
      if (m_sh.size() == 0 && pre > 0) begin
        w = m_fifo.pop_front();
        word_bits(w, m_sh);
      end
      if (u_if.valid_i && pre != DEPTH) m_fifo.push_back(u_if.data_i);
    end
  endtask

  always @(posedge clk_i or negedge rstn_i) model_edge();

  function automatic logic [LW+3:0] dut_vec();
    return {u_if.seq_valid_o, u_if.seq_o, u_if.busy_o, u_if.ready_o, u_if.level_o};
  endfunction

  function automatic logic [LW+3:0] mdl_vec();
    logic v;
    logic b;
    v = (m_sh.size() != 0);
    b = v ? m_sh[0] : 1'b0;
    return {v, b, v, (m_fifo.size() != DEPTH), LW'(m_fifo.size())};
  endfunction

  localparam logic [LW+3:0] RST_VEC = {1'b0, 1'b0, 1'b0, 1'b1, {LW{1'b0}}};

  task automatic test_reset();
    rstn_i = 1'b0;
    u_if.valid_i = 1'b1;
    u_if.data_i  = WIDTH'($urandom);
    repeat (3) @(negedge clk_i);
    if (dut_vec() !== RST_VEC) begin
      errors++;
      $display("FAIL reset_hold: got %b want %b", dut_vec(), RST_VEC);
    end
    checks++;
    rstn_i = 1'b1;
    u_if.valid_i = 1'b0;
    @(negedge clk_i);
    if (dut_vec() !== RST_VEC) begin
      errors++;
      $display("FAIL reset_release: got %b want %b", dut_vec(), RST_VEC);
    end
    checks++;
  endtask

  task automatic test_single(input logic [WIDTH-1:0] w, input string nm);
    logic exp_v;
    logic exp_b;
    u_if.valid_i = 1'b1;
    u_if.data_i  = w;
    @(negedge clk_i);
    u_if.valid_i = 1'b0;
    for (int i = 1; i <= NBITS + 2; i++) begin
      @(negedge clk_i);
      exp_v = (i <= NBITS);
      exp_b = 1'b0;
      if (i <= WIDTH) exp_b = w[WIDTH-i];
      else if (i == NBITS) exp_b = ^w;
      if ({u_if.seq_valid_o, u_if.seq_o} !== {exp_v, exp_b}) begin
        errors++;
        $display("FAIL %s cycle %0d: valid/bit got %b%b want %b%b", nm, i,
                 u_if.seq_valid_o, u_if.seq_o, exp_v, exp_b);
      end
      checks++;
      if (dut_vec() !== mdl_vec()) begin
        errors++;
        $display("FAIL %s_model cycle %0d: got %b want %b", nm, i, dut_vec(), mdl_vec());
      end
      checks++;
    end
    if (u_if.busy_o !== 1'b0) begin
      errors++;
      $display("FAIL %s_busy_end: got %b want 0", nm, u_if.busy_o);
    end
    checks++;
  endtask

  task automatic test_back_to_back();
    logic exp [$];
    logic exp_v;
    logic exp_b;
    word_bits(8'hFF, exp);
    word_bits(8'h00, exp);
    u_if.valid_i = 1'b1;
    u_if.data_i  = 8'hFF;
    @(negedge clk_i);
    u_if.data_i  = 8'h00;
    @(negedge clk_i);
    u_if.valid_i = 1'b0;
    for (int i = 1; i <= 2 * NBITS + 2; i++) begin
      if (i > 1) @(negedge clk_i);
      exp_v = (i <= exp.size());
      exp_b = exp_v ? exp[i-1] : 1'b0;
      if ({u_if.seq_valid_o, u_if.seq_o} !== {exp_v, exp_b}) begin
        errors++;
        $display("FAIL b2b cycle %0d: valid/bit got %b%b want %b%b", i,
                 u_if.seq_valid_o, u_if.seq_o, exp_v, exp_b);
      end
      checks++;
    end
  endtask

  task automatic test_full();
    logic [WIDTH-1:0] words [6];
    logic             exp [$];
    logic             got [$];
    int               idx;
    logic             acc;
    logic             saw_full;
    int               budget;
    for (int i = 0; i < 6; i++) begin
      words[i] = WIDTH'($urandom);
      word_bits(words[i], exp);
    end
    idx = 0;
    saw_full = 1'b0;
    u_if.valid_i = 1'b1;
    u_if.data_i  = words[0];
    budget = 0;
    while ((idx < 6 || m_sh.size() != 0 || m_fifo.size() != 0) && budget < 200) begin
      acc = u_if.valid_i && u_if.ready_o;
      @(negedge clk_i);
      budget++;
      if (u_if.seq_valid_o) got.push_back(u_if.seq_o);
      if (u_if.level_o == LW'(DEPTH) && u_if.ready_o == 1'b0) saw_full = 1'b1;
      if (dut_vec() !== mdl_vec()) begin
        errors++;
        $display("FAIL full_model cycle %0d: got %b want %b", budget, dut_vec(), mdl_vec());
      end
      checks++;
      if (acc) idx++;
      if (idx >= 6) u_if.valid_i = 1'b0;
      else u_if.data_i = words[idx];
    end
    u_if.valid_i = 1'b0;
    if (budget >= 200) begin
      errors++;
      $display("FAIL full_drain: timed out after %0d cycles", budget);
    end
    checks++;
    if (saw_full !== 1'b1) begin
      errors++;
      $display("FAIL full_level: saw full=%b want 1", saw_full);
    end
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL full_order: got %0d bits want %0d bits (or contents differ)", got.size(), exp.size());
    end
    checks++;
  endtask

  task automatic test_reset_mid();
    logic [WIDTH-1:0] w0;
    w0 = 8'hA5;
    u_if.valid_i = 1'b1;
    u_if.data_i  = w0;
    @(negedge clk_i);
    u_if.data_i  = WIDTH'($urandom);
    @(negedge clk_i);
    u_if.data_i  = WIDTH'($urandom);
    @(negedge clk_i);
    u_if.valid_i = 1'b0;
    repeat (2) @(negedge clk_i);
    if ({u_if.seq_valid_o, u_if.seq_o, u_if.level_o} !== {1'b1, w0[WIDTH-4], LW'(2)}) begin
      errors++;
      $display("FAIL mid_bit3: valid/bit/level got %b%b %0d want 1%b 2",
               u_if.seq_valid_o, u_if.seq_o, u_if.level_o, w0[WIDTH-4]);
    end
    checks++;
    #2 rstn_i = 1'b0;
    #1;
    if (dut_vec() !== RST_VEC) begin
      errors++;
      $display("FAIL mid_async: got %b want %b", dut_vec(), RST_VEC);
    end
    checks++;
    @(negedge clk_i);
    rstn_i = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk_i);
      if (dut_vec() !== RST_VEC || dut_vec() !== mdl_vec()) begin
        errors++;
        $display("FAIL mid_after cycle %0d: got %b want %b", i, dut_vec(), RST_VEC);
      end
      checks++;
    end
  endtask

  task automatic test_random();
    logic acc;
    for (int i = 0; i < 400; i++) begin
      acc = u_if.valid_i && u_if.ready_o;
      if (acc || !u_if.valid_i) begin
        u_if.valid_i = ($urandom_range(0, 3) != 0);
        u_if.data_i  = WIDTH'($urandom);
      end
      @(negedge clk_i);
      if (dut_vec() !== mdl_vec()) begin
        errors++;
        $display("FAIL random cycle %0d: got %b want %b", i, dut_vec(), mdl_vec());
      end
      checks++;
    end
    u_if.valid_i = 1'b0;
    repeat (DEPTH * NBITS + NBITS + 2) @(negedge clk_i);
    if (dut_vec() !== RST_VEC) begin
      errors++;
      $display("FAIL random_drain: got %b want %b", dut_vec(), RST_VEC);
    end
    checks++;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    u_if.valid_i = 1'b0;
    u_if.data_i  = '0;
    test_reset();
    test_single(8'hB4, "single_b4");
    test_single(8'h07, "single_07");
    test_single(WIDTH'($urandom), "single_rand");
    test_back_to_back();
    repeat (3) @(negedge clk_i);
    test_full();
    repeat (3) @(negedge clk_i);
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
